motor_bridge_ctrl: RTL and testbench

Single-channel H-bridge driver that sits directly downstream of the motor direction peripheral: it consumes one motor's `adelante`/`atras` pair plus an 8-bit duty value and produces the two bridge input signals. It generates the PWM, forces a dead-time coast interval on every departure from a driving state, and flags illegal direction requests. The SoC instantiates it once per motor.

---
 rtl/motor_bridge_ctrl.sv | 125 ++++++++++++
 tb/tb_motor_bridge_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/motor_bridge_ctrl.sv
// H-bridge driver: PWM generation, dead-time coast on drive exit, illegal-request flag.
// Latency: request registered at edge 0, state and bridge outputs updated at edge 1.
// No backpressure: requests are level-sampled every clock; requests are ignored during DEAD.
module motor_bridge_ctrl #(
  parameter int PRESCALE    = 4,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adelante,
  input  logic       atras,
  input  logic [7:0] duty,
  input  logic       en,
  output logic       in_a,
  output logic       in_b,
  output logic       busy,
  output logic       fault
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_REV, ST_DEAD} state_e;

  logic          fwd_q, rev_q, en_q;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    pcnt_q, pcnt_d;
  logic [7:0]    duty_l_q, duty_l_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  state_e        state_q, state_d;
  logic          in_a_q, in_b_q, busy_q, fault_q;
  logic          in_a_d, in_b_d, busy_d, fault_d;
  logic          tick, pwm, req_fwd, req_rev;

  // Sample the direction requests and enable once per clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_q <= 1'b0;
      rev_q <= 1'b0;
      en_q  <= 1'b0;
    end else begin
      fwd_q <= adelante;
      rev_q <= atras;
      en_q  <= en;
    end
  end

  assign req_fwd = fwd_q & ~rev_q & en_q;
  assign req_rev = rev_q & ~fwd_q & en_q;

  // Free-running prescaler and PWM counter; duty is latched only at the period wrap.
  always_comb begin
    tick     = (pre_q == PRE_LAST);
    pre_d    = tick ? '0 : pre_q + PW'(1);
    pcnt_d   = tick ? pcnt_q + 8'd1 : pcnt_q;
    duty_l_d = (tick && pcnt_q == 8'hFF) ? duty : duty_l_q;
    pwm      = (pcnt_q < duty_l_q);
  end

  // Next state, dead-time counter and output decode from the next state.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_fwd)      state_d = ST_FWD;
        else if (req_rev) state_d = ST_REV;
      end
      ST_FWD: begin
        if (!req_fwd) begin
          state_d = ST_DEAD;
          dcnt_d  = DEAD_LOAD;
        end
      end
      ST_REV: begin
        if (!req_rev) begin
          state_d = ST_DEAD;
          dcnt_d  = DEAD_LOAD;
        end
      end
      ST_DEAD: begin
        if (dcnt_q == '0) state_d = ST_IDLE;
        else              dcnt_d  = dcnt_q - DW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    in_a_d  = (state_d == ST_FWD) & pwm;
    in_b_d  = (state_d == ST_REV) & pwm;
    busy_d  = (state_d == ST_DEAD);
    fault_d = fwd_q & rev_q;
  end

  // State, counters and registered bridge outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q    <= '0;
      pcnt_q   <= '0;
      duty_l_q <= '0;
      dcnt_q   <= '0;
      state_q  <= ST_IDLE;
      in_a_q   <= 1'b0;
      in_b_q   <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      pcnt_q   <= pcnt_d;
      duty_l_q <= duty_l_d;
      dcnt_q   <= dcnt_d;
      state_q  <= state_d;
      in_a_q   <= in_a_d;
      in_b_q   <= in_b_d;
      busy_q   <= busy_d;
      fault_q  <= fault_d;
    end
  end

  assign in_a  = in_a_q;
  assign in_b  = in_b_q;
  assign busy  = busy_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_motor_bridge_ctrl.sv
// Bench for motor_bridge_ctrl: vector table, corner sequences and a cycle model.
// Model predicts outputs from edge counts since reset and a remaining-dead-time count.
// Inputs driven and outputs sampled on the falling edge.
module tb_motor_bridge_ctrl;
  localparam int P = 1;
  localparam int D = 10;

  logic       clk, rst, adelante, atras, en;
  logic [7:0] duty;
  logic       in_a, in_b, busy, fault;

  int n_assert = 0;
  int n_fail   = 0;

  motor_bridge_ctrl #(.PRESCALE(P), .DEAD_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .adelante(adelante), .atras(atras), .duty(duty),
    .en(en), .in_a(in_a), .in_b(in_b), .busy(busy), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 forward, 2 reverse, 3 coasting.
  int         m_n, m_mode, m_left;
  bit         m_fwd, m_rev, m_en;
  logic [7:0] m_dl;
  bit         e_a, e_b, e_busy, e_fault;

  function automatic void model_reset();
    m_n = 0; m_mode = 0; m_left = 0;
    m_fwd = 0; m_rev = 0; m_en = 0; m_dl = 8'd0;
    e_a = 0; e_b = 0; e_busy = 0; e_fault = 0;
  endfunction

  task automatic model_step();
    int pc;
    int nm;
    bit pw, rf, rr;
    pc = (m_n / P) % 256;
    pw = (pc < int'(m_dl));
    rf = m_fwd && !m_rev && m_en;
    rr = m_rev && !m_fwd && m_en;
    nm = m_mode;
    case (m_mode)
      0: nm = rf ? 1 : (rr ? 2 : 0);
      1: if (!rf) begin nm = 3; m_left = D; end
      2: if (!rr) begin nm = 3; m_left = D; end
      default: if (m_left == 1) nm = 0; else m_left = m_left - 1;
    endcase
    e_a     = (nm == 1) && pw;
    e_b     = (nm == 2) && pw;
    e_busy  = (nm == 3);
    e_fault = m_fwd && m_rev;
    m_mode  = nm;
    if (((m_n + 1) % (256 * P)) == 0) m_dl = duty;
    m_n   = m_n + 1;
    m_fwd = adelante;
    m_rev = atras;
    m_en  = en;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("in_a", in_a, e_a);
    chk("in_b", in_b, e_b);
    chk("busy", busy, e_busy);
    chk("fault", fault, e_fault);
    chk("a_and_b", in_a & in_b, 0);
  endtask

  task automatic set_in(input bit a, input bit b, input bit e, input logic [7:0] d);
    adelante = a; atras = b; en = e; duty = d;
  endtask

  typedef struct {
    bit         a, b, e;
    logic [7:0] d;
    int         cyc;
    bit         x_busy, x_fault, x_a, x_b;
  } vec_t;

  vec_t vt[7];

  initial begin
    int  bcnt, run, fb, fi;
    bit  sa, sb, found;

    vt[0] = '{1, 0, 1, 8'd128, 600, 0, 0, 1, 0};
    vt[1] = '{0, 0, 1, 8'd128,  20, 0, 0, 0, 0};
    vt[2] = '{0, 1, 1, 8'd128, 600, 0, 0, 0, 1};
    vt[3] = '{1, 1, 1, 8'd128,  30, 0, 1, 0, 0};
    vt[4] = '{1, 0, 0, 8'd128,  30, 0, 0, 0, 0};
    vt[5] = '{1, 0, 1, 8'd0,   600, 0, 0, 0, 0};
    vt[6] = '{1, 0, 1, 8'd255, 600, 0, 0, 1, 0};

    rst = 1'b0;
    set_in(0, 0, 0, 8'd128);
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_in_a", in_a, 0);
    chk("rst_in_b", in_b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    rst = 1'b1;

    // Table-driven segments: hold each input set, then check end state and activity.
    for (int r = 0; r < 7; r++) begin
      set_in(vt[r].a, vt[r].b, vt[r].e, vt[r].d);
      sa = 0; sb = 0;
      for (int i = 0; i < vt[r].cyc; i++) begin
        tick();
        if (i >= vt[r].cyc / 2) begin
          sa = sa | in_a;
          sb = sb | in_b;
        end
      end
      chk($sformatf("vec%0d_busy", r), busy, vt[r].x_busy);
      chk($sformatf("vec%0d_fault", r), fault, vt[r].x_fault);
      chk($sformatf("vec%0d_a_seen", r), sa, vt[r].x_a);
      chk($sformatf("vec%0d_b_seen", r), sb, vt[r].x_b);
    end

    // Reversal forward->reverse at duty 255, aligned to the start of a period.
    for (int i = 0; i < 256 && (m_n % 256) != 0; i++) tick();
    set_in(0, 1, 1, 8'd255);
    bcnt = 0; fb = -1; fi = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy) bcnt++;
      if (busy && fb < 0) fb = i;
      if (in_b && fi < 0) fi = i;
    end
    chk("rev_busy_cycles", bcnt, D);
    run = (fb >= 0 && fi >= 0) ? fi - fb : -1;
    chk("rev_coast_cycles", run, D + 1);

    // Both requests while forward: fault next edge, coast, then resume.
    set_in(1, 0, 1, 8'd128);
    repeat (30) tick();
    set_in(1, 1, 1, 8'd128);
    tick();
    chk("flt_i0", fault, 0);
    tick();
    chk("flt_i1", fault, 1);
    chk("flt_busy", busy, 1);
    repeat (20) tick();
    chk("flt_idle_busy", busy, 0);
    chk("flt_idle_a", in_a, 0);
    set_in(1, 0, 1, 8'd128);
    repeat (3) tick();
    chk("flt_clear", fault, 0);
    chk("flt_resume_busy", busy, 0);

    // Enable dropped for a single cycle while reverse.
    set_in(0, 1, 1, 8'd128);
    repeat (30) tick();
    en = 1'b0;
    tick();
    en = 1'b1;
    bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy) bcnt++;
    end
    chk("en_drop_busy_cycles", bcnt, D);

    // Asynchronous reset in the middle of a coast interval.
    set_in(0, 0, 1, 8'd128);
    repeat (4) tick();
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_dead_busy", busy, 0);
    chk("rst_dead_a", in_a, 0);
    chk("rst_dead_b", in_b, 0);
    chk("rst_dead_fault", fault, 0);
    model_reset();
    set_in(1, 0, 1, 8'd128);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 260; i++) begin
      tick();
      if (i == 1)   chk("post_rst_busy", busy, 0);
      if (i == 255) chk("post_rst_a_before_wrap", in_a, 0);
      if (i == 256) chk("post_rst_a_after_wrap", in_a, 1);
    end

    // Asynchronous reset while the PWM output is high.
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (in_a) found = 1;
      else tick();
    end
    chk("pwm_high_found", found, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_pwm_a", in_a, 0);
    chk("rst_pwm_b", in_b, 0);
    chk("rst_pwm_busy", busy, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
